// File: rtl/async_fifo_pkg.sv
// ============================================================================
//  Module  : async_fifo_pkg
//  Brief   : Default geometry and pointer-width helper for the async_fifo block.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package async_fifo_pkg;

    localparam int C_DEPTH      = 512;
    localparam int C_DATA_WIDTH = 64;

    // Pointer carries one extra wrap bit above the address bits.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage : async_fifo_pkg

`default_nettype wire

// File: rtl/async_fifo_mem.sv
// ============================================================================
//  Module  : async_fifo_mem
//  Brief   : Simple dual-port RAM, synchronous write, registered read, no reset.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo_mem #(
    parameter int DEPTH      = 512,
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [ADDR_W-1:0]     i_wr_addr,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic                  i_rd_en,
    input  logic [ADDR_W-1:0]     i_rd_addr,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_rd_q;

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Read register only loads on an accepted read, so it holds otherwise.
    always_ff @(posedge i_clk) begin
        if (i_rd_en) begin
            r_rd_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_data = r_rd_q;

endmodule : async_fifo_mem

`default_nettype wire

// File: rtl/async_fifo.sv
// ============================================================================
//  Module  : async_fifo
//  Brief   : Single-clock FIFO with full/empty flags; rejects overflow/underflow.
//            Optional sticky error flags when ASYNC_FIFO_ERR_FLAGS_EN is defined.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module async_fifo
    import async_fifo_pkg::*;
#(
    parameter int DEPTH      = C_DEPTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_wr_en,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    output logic                  o_full,
    input  logic                  i_rd_en,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    output logic                  o_empty
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    ,
    output logic                  o_overflow,
    output logic                  o_underflow
`endif
);

    localparam int C_ADDR_W = $clog2(DEPTH);
    localparam int C_PTR_W  = ptr_width(DEPTH);

    logic [C_PTR_W-1:0]    r_wr_ptr;
    logic [C_PTR_W-1:0]    r_rd_ptr;
    logic                  r_rd_loaded;
    logic                  w_empty;
    logic                  w_full;
    logic                  w_wr_accept;
    logic                  w_rd_accept;
    logic [DATA_WIDTH-1:0] w_mem_rd_data;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[C_ADDR_W] != r_rd_ptr[C_ADDR_W]) &&
                     (r_wr_ptr[C_ADDR_W-1:0] == r_rd_ptr[C_ADDR_W-1:0]);

    assign w_wr_accept = i_wr_en & ~w_full;
    assign w_rd_accept = i_rd_en & ~w_empty;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_rd_loaded <= 1'b0;
        end else begin
            if (w_wr_accept) begin
                r_wr_ptr <= r_wr_ptr + C_PTR_W'(1);
            end
            if (w_rd_accept) begin
                r_rd_ptr    <= r_rd_ptr + C_PTR_W'(1);
                r_rd_loaded <= 1'b1;
            end
        end
    end

    async_fifo_mem #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (C_ADDR_W)
    ) u_mem (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_accept),
        .i_wr_addr (r_wr_ptr[C_ADDR_W-1:0]),
        .i_wr_data (i_wr_data),
        .i_rd_en   (w_rd_accept),
        .i_rd_addr (r_rd_ptr[C_ADDR_W-1:0]),
        .o_rd_data (w_mem_rd_data)
    );

    // The RAM read register has no reset; mask it to zero until the first
    // read after reset has loaded it.
    assign o_rd_data = r_rd_loaded ? w_mem_rd_data : '0;
    assign o_full    = w_full;
    assign o_empty   = w_empty;

`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic r_overflow;
    logic r_underflow;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (i_wr_en && w_full) begin
                r_overflow <= 1'b1;
            end
            if (i_rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign o_overflow  = r_overflow;
    assign o_underflow = r_underflow;
`endif

endmodule : async_fifo

`default_nettype wire

// File: tb/tb_async_fifo.sv
// ============================================================================
//  Module  : tb_async_fifo
//  Brief   : Randomized self-checking bench for async_fifo against a queue model.
//  Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_async_fifo;

    localparam int C_DEPTH = 512;
    localparam int C_DW    = 64;

    logic            i_clk     = 1'b0;
    logic            i_rstn    = 1'b0;
    logic            i_wr_en   = 1'b0;
    logic [C_DW-1:0] i_wr_data = '0;
    logic            i_rd_en   = 1'b0;
    logic            o_full;
    logic            o_empty;
    logic [C_DW-1:0] o_rd_data;
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
    logic            o_overflow;
    logic            o_underflow;
`endif

    async_fifo #(
        .DEPTH      (C_DEPTH),
        .DATA_WIDTH (C_DW)
    ) dut (
        .i_clk       (i_clk),
        .i_rstn      (i_rstn),
        .i_wr_en     (i_wr_en),
        .i_wr_data   (i_wr_data),
        .o_full      (o_full),
        .i_rd_en     (i_rd_en),
        .o_rd_data   (o_rd_data),
        .o_empty     (o_empty)
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        ,
        .o_overflow  (o_overflow),
        .o_underflow (o_underflow)
`endif
    );

    always #5 i_clk = ~i_clk;

    int              n_total = 0;
    int              n_bad   = 0;
    logic [C_DW-1:0] model_q [$];
    logic [C_DW-1:0] exp_rd  = '0;
    logic            exp_ov  = 1'b0;
    logic            exp_un  = 1'b0;

    task automatic check(input string tag, input logic [C_DW-1:0] got,
                         input logic [C_DW-1:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".empty"}, C_DW'(o_empty), C_DW'(model_q.size() == 0));
        check({tag, ".full"},  C_DW'(o_full),  C_DW'(model_q.size() == C_DEPTH));
        check({tag, ".rdata"}, o_rd_data, exp_rd);
`ifdef ASYNC_FIFO_ERR_FLAGS_EN
        check({tag, ".ovf"}, C_DW'(o_overflow),  C_DW'(exp_ov));
        check({tag, ".unf"}, C_DW'(o_underflow), C_DW'(exp_un));
`endif
    endtask

    function automatic logic [C_DW-1:0] rand_word();
        return {$urandom, $urandom};
    endfunction

    // One clock of stimulus; the model applies the FIFO rules using the
    // occupancy seen before the edge, then outputs are compared after it.
    task automatic cycle(input string tag, input logic we,
                         input logic [C_DW-1:0] wd, input logic re);
        bit was_full;
        bit was_empty;
        was_full  = (model_q.size() == C_DEPTH);
        was_empty = (model_q.size() == 0);
        i_wr_en   = we;
        i_wr_data = wd;
        i_rd_en   = re;
        @(posedge i_clk);
        #1;
        if (we && was_full)  exp_ov = 1'b1;
        if (re && was_empty) exp_un = 1'b1;
        if (re && !was_empty) exp_rd = model_q.pop_front();
        if (we && !was_full)  model_q.push_back(wd);
        i_wr_en = 1'b0;
        i_rd_en = 1'b0;
        check_state(tag);
    endtask

    task automatic model_reset();
        model_q.delete();
        exp_rd = '0;
        exp_ov = 1'b0;
        exp_un = 1'b0;
    endtask

    initial begin
        // Reset held for five clocks.
        i_rstn = 1'b0;
        repeat (5) @(posedge i_clk);
        #1;
        model_reset();
        check_state("reset");
        i_rstn = 1'b1;

        // Fill to exactly DEPTH words; full must appear only after the last.
        for (int i = 0; i < C_DEPTH; i++) begin
            cycle("fill", 1'b1, rand_word(), 1'b0);
        end

        // Rejected write while full.
        cycle("overflow", 1'b1, rand_word(), 1'b0);

        // Drain returns the original words in order.
        for (int i = 0; i < C_DEPTH; i++) begin
            cycle("drain", 1'b0, '0, 1'b1);
        end

        // Rejected reads while empty: data holds.
        cycle("underflow", 1'b0, '0, 1'b1);
        cycle("underflow2", 1'b1, rand_word(), 1'b1);
        cycle("after_unf", 1'b0, '0, 1'b1);

        // Concurrent write/read at a level of three.
        for (int i = 0; i < 3; i++) begin
            cycle("lvl3_fill", 1'b1, rand_word(), 1'b0);
        end
        for (int i = 0; i < 4; i++) begin
            cycle("lvl3_rw", 1'b1, 64'hA5, 1'b1);
        end
        check("lvl3_level", C_DW'(model_q.size()), C_DW'(3));

        // Mixed traffic across pointer wrap, biased to reach both extremes.
        for (int i = 0; i < 1000; i++) begin
            logic we;
            logic re;
            if (i < 400) begin
                we = ($urandom_range(0, 3) != 0);
                re = ($urandom_range(0, 3) == 0);
            end else if (i < 800) begin
                we = ($urandom_range(0, 3) == 0);
                re = ($urandom_range(0, 3) != 0);
            end else begin
                we = $urandom_range(0, 1) != 0;
                re = $urandom_range(0, 1) != 0;
            end
            cycle("mixed", we, rand_word(), re);
        end

        // Asynchronous reset mid-operation, asserted away from the clock edge.
        for (int i = 0; i < 10; i++) begin
            cycle("pre_rst", 1'b1, rand_word(), (i % 3) == 0);
        end
        #2;
        i_rstn = 1'b0;
        #1;
        model_reset();
        check_state("async_rst");
        @(posedge i_clk);
        #1;
        check_state("rst_hold");
        i_rstn = 1'b1;

        // Fresh traffic after reset, then drain to empty.
        for (int i = 0; i < 20; i++) begin
            cycle("post_rst", 1'b1, rand_word(), (i % 4) == 3);
        end
        while (model_q.size() != 0) begin
            cycle("final_drain", 1'b0, '0, 1'b1);
        end
        cycle("final_unf", 1'b0, '0, 1'b1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_async_fifo

`default_nettype wire
